// File: rtl/reg_bus_master_if.sv
// Command/response handshake and register-bus signals for reg_bus_master.
// master = the bus master block, slave = requester plus register target.
interface reg_bus_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_wr;
  logic       cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       bus_wr;
  logic       bus_addr;
  logic [7:0] bus_din;
  logic [7:0] bus_dout;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, bus_dout,
    output cmd_ready, rsp_valid, rsp_rdata, bus_wr, bus_addr, bus_din
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, bus_dout,
    input  cmd_ready, rsp_valid, rsp_rdata, bus_wr, bus_addr, bus_din
  );
endinterface

// File: rtl/reg_bus_master.sv
// Single-outstanding command to register-bus master with configurable read latency.
// Optional response counters wr_cnt/rd_cnt enabled by macro REG_BUS_MASTER_STATS_EN.
module reg_bus_master #(
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  reg_bus_master_if.master      bif
`ifdef REG_BUS_MASTER_STATS_EN
  ,
  output logic [7:0]            wr_cnt,
  output logic [7:0]            rd_cnt
`endif
);

  localparam int         DATA_W    = 8;
  localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_REQ,
    READ_WAIT,
    RESP
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                armed;
  logic                lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [1:0]          wait_cnt;
  logic [DATA_W-1:0]   rdata;
  logic                ready;
  logic                rsp_vld;
  logic                wr_strobe;
  logic                addr_drv;
  logic [DATA_W-1:0]   din_drv;
  logic                accept;

  assign accept        = bif.cmd_valid && ready;
  assign bif.cmd_ready = ready;
  assign bif.rsp_valid = rsp_vld;
  assign bif.rsp_rdata = rdata;
  assign bif.bus_wr    = wr_strobe;
  assign bif.bus_addr  = addr_drv;
  assign bif.bus_din   = din_drv;

  // armed holds cmd_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    rsp_vld   = 1'b0;
    wr_strobe = 1'b0;
    addr_drv  = 1'b1;
    din_drv   = '0;
    case (state)
      IDLE: begin
        ready = armed;
        if (bif.cmd_valid && armed)
          state_nxt = bif.cmd_wr ? WRITE : READ_REQ;
      end
      WRITE: begin
        wr_strobe = 1'b1;
        addr_drv  = lat_addr;
        din_drv   = lat_wdata;
        state_nxt = RESP;
      end
      READ_REQ: begin
        addr_drv  = lat_addr;
        state_nxt = READ_WAIT;
      end
      READ_WAIT: begin
        if (wait_cnt == 2'd0)
          state_nxt = RESP;
      end
      RESP: begin
        rsp_vld = 1'b1;
        if (bif.rsp_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, read-wait counter and response data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_addr  <= 1'b0;
      lat_wdata <= '0;
      wait_cnt  <= 2'd0;
      rdata     <= '0;
    end else begin
      if (accept) begin
        lat_addr  <= bif.cmd_addr;
        lat_wdata <= bif.cmd_wdata;
      end
      if (state == READ_REQ)
        wait_cnt <= WAIT_LOAD;
      else if (state == READ_WAIT && wait_cnt != 2'd0)
        wait_cnt <= wait_cnt - 2'd1;
      if (state == WRITE)
        rdata <= '0;
      else if (state == READ_WAIT && wait_cnt == 2'd0)
        rdata <= bif.bus_dout;
    end
  end

`ifdef REG_BUS_MASTER_STATS_EN
  logic lat_wr;
  logic rsp_fire;

  assign rsp_fire = rsp_vld && bif.rsp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_wr <= 1'b0;
      wr_cnt <= 8'h00;
      rd_cnt <= 8'h00;
    end else begin
      if (accept)
        lat_wr <= bif.cmd_wr;
      if (rsp_fire) begin
        if (lat_wr)
          wr_cnt <= wr_cnt + 8'd1;
        else
          rd_cnt <= rd_cnt + 8'd1;
      end
    end
  end
`endif

endmodule
